servo_slew_latch: RTL and testbench
===================================

// Module: servo_slew_latch
// PURPOSE
//  Successor to the plain servo position latch: captures NUM_SERVOS packed position words from the AVR
//  interface on a trigger and drives them to the servo PWM generators. Optionally rate-limits each channel
//  towards its new target (MAX_STEP counts per slew tick) so servos never jump. Fully synchronous; the
//  asynchronous AVR trigger is synchronised and edge-detected internally. Reports when all channels settle.
// PARAMETERS
//  NUM_SERVOS   1     number of servo channels
//  WIDTH        8     bits per position word
//  DEFAULT_POS  127   per-channel reset/park position (must be < 2**WIDTH)
//  MAX_STEP     4     max position change per channel per slew tick (1 .. 2**WIDTH-1)
//  TICK_DIV     1000  clk cycles per slew tick (>= 1; 1 = tick every cycle)
// PORTS
//  clk            in   1                  system clock; all state on rising edge
//  rst            in   1                  synchronous, active-high reset
//  trigger        in   1                  AVR latch request, asynchronous level; rising edge = latch
//  pos_buffer     in   WIDTH*NUM_SERVOS   new positions, channel i at [WIDTH*i +: WIDTH]
//  slew_en        in   1                  1 = rate-limited ramp, 0 = output follows target directly
//  target_buffer  out  WIDTH*NUM_SERVOS   last latched positions (registered)
//  output_buffer  out  WIDTH*NUM_SERVOS   positions driven to PWM generators (registered)
//  settled        out  1                  1 when output_buffer == target_buffer on every channel
// BEHAVIOUR
//  - Reset (rst high at an edge): every channel of target_buffer and output_buffer = DEFAULT_POS; tick
//    prescaler = 0; trigger sync flops = 0; settled = 1. rst overrides every other input in that cycle.
//  - Trigger path: 2-flop synchroniser (s1,s2) + history flop s3; latch = s2 & ~s3.
//    trigger first high before edge k -> s1 at k, s2 at k+1, target_buffer <= pos_buffer at edge k+2
//    (pos_buffer sampled at edge k+2; must be stable from edge k). One latch per rising edge; a held-high
//    trigger never re-latches. Trigger pulses shorter than 1 clk may be missed (documented AVR limit).
//  - Prescaler: counts 0..TICK_DIV-1 continuously, wraps to 0; tick = (count == TICK_DIV-1). Runs
//    regardless of slew_en; not reset by latch events.
//  - slew_en = 0: output_buffer <= target_buffer every edge (one cycle behind target), plus in the latch
//    cycle output_buffer <= pos_buffer directly, so target and output update on the same edge k+2.
//  - slew_en = 1, per channel on tick edges only (using current registered target, unsigned WIDTH maths):
//      out < tgt: out <= out + min(MAX_STEP, tgt-out)
//      out > tgt: out <= out - min(MAX_STEP, out-tgt)
//      out == tgt: hold. Never overshoots, never wraps (difference taken as tgt-out or out-tgt, no underflow).
//    Non-tick edges: output_buffer holds.
//  - Latch and tick same edge (slew_en = 1): target loads new value; step that edge uses the OLD target.
//  - New latch mid-ramp: ramp redirects toward the new target from the current output; no restart delay.
//  - slew_en 1->0 mid-ramp: output snaps to target at the next edge. 0->1: ramping resumes at next tick.
//  - settled: combinational compare of the two registered buses; falls the edge target changes (slew_en=1),
//    rises the edge the final step lands.
//  - rst mid-ramp: both buses return to DEFAULT_POS at that edge; a trigger in the sync pipe is discarded.
// TESTING
//  1 Reset: rst=1 2 cycles, NUM_SERVOS=2 -> target/output = {8'd127,8'd127}, settled=1.
//  2 Direct mode: slew_en=0, pos_buffer={8'd10,8'd250}, trigger rise before edge k -> both buses =
//    {10,250} at edge k+2; trigger held high 50 cycles and pos_buffer changed -> no further latch.
//  3 Ramp: slew_en=1, MAX_STEP=4, TICK_DIV=3, ch0 127->138 -> output 131,135,138 on three successive
//    ticks (every 3rd edge), settled 0 then 1 on the edge output reaches 138; downward 138->0 no wrap.
//  4 Redirect: ramping 127->200, latch 100 when output=143 -> output steps 139,135,... down to 100 exactly.
//  5 Coincidence/mode: latch on a tick edge -> that step uses old target; drop slew_en mid-ramp ->
//    output = target next edge; TICK_DIV=1 -> step every cycle.
//  6 Reset mid-ramp with trigger in synchroniser -> buses = 127 next edge, no latch afterwards.

Source files
------------

// File: rtl/servo_slew_latch.sv
// Captures packed servo positions on a synchronised trigger edge and drives them to the PWM
// generators, either directly or rate-limited toward the latched target on prescaled slew ticks.
module servo_slew_latch #(
    parameter int NUM_SERVOS  = 1,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_POS = 127,
    parameter int MAX_STEP    = 4,
    parameter int TICK_DIV    = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        trigger,
    input  logic [WIDTH*NUM_SERVOS-1:0] pos_buffer,
    input  logic                        slew_en,
    output logic [WIDTH*NUM_SERVOS-1:0] target_buffer,
    output logic [WIDTH*NUM_SERVOS-1:0] output_buffer,
    output logic                        settled
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(MAX_STEP);
    localparam logic [WIDTH-1:0] PARK_CH = WIDTH'(DEFAULT_POS);
    localparam logic [WIDTH*NUM_SERVOS-1:0] PARK = {NUM_SERVOS{PARK_CH}};

    logic                        s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [WIDTH*NUM_SERVOS-1:0] tgt_q, tgt_d;
    logic [WIDTH*NUM_SERVOS-1:0] out_q, out_d;
    logic                        latch;
    logic                        tick;

    // s3 remembers the previous synchronised level so a held-high trigger latches only once.
    assign latch = s2_q & ~s3_q;
    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    assign tgt_d = latch ? pos_buffer : tgt_q;

    for (genvar g = 0; g < NUM_SERVOS; g++) begin : g_ch
        logic [WIDTH-1:0] tgt, cur, gap_up, gap_dn, step_up, step_dn, nxt;

        assign tgt     = tgt_q[g*WIDTH +: WIDTH];
        assign cur     = out_q[g*WIDTH +: WIDTH];
        // Gaps are only used on the side where they cannot underflow.
        assign gap_up  = tgt - cur;
        assign gap_dn  = cur - tgt;
        assign step_up = (gap_up > STEP) ? STEP : gap_up;
        assign step_dn = (gap_dn > STEP) ? STEP : gap_dn;

        always_comb begin
            nxt = cur;
            if (!slew_en) begin
                nxt = latch ? pos_buffer[g*WIDTH +: WIDTH] : tgt;
            end else if (tick) begin
                if (cur < tgt) begin
                    nxt = cur + step_up;
                end else if (cur > tgt) begin
                    nxt = cur - step_dn;
                end
            end
        end

        assign out_d[g*WIDTH +: WIDTH] = nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            cnt_q <= '0;
            tgt_q <= PARK;
            out_q <= PARK;
        end else begin
            s1_q  <= trigger;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            cnt_q <= cnt_d;
            tgt_q <= tgt_d;
            out_q <= out_d;
        end
    end

    assign target_buffer = tgt_q;
    assign output_buffer = out_q;
    assign settled       = (out_q == tgt_q);

endmodule

// File: tb/tb_servo_slew_latch.sv
// Bench for servo_slew_latch: a two-channel instance with a 3-cycle slew tick and a one-channel
// instance ticking every cycle, both compared against an arithmetic reference model.
module tb_servo_slew_latch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        slew_en = 1'b0;
    logic [15:0] pos = 16'h0;
    logic [15:0] tgt_a, out_a;
    logic [7:0]  tgt_b, out_b;
    logic        set_a, set_b;
    logic [49:0] dut_vec;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int m_tgt_a[2];
    int m_out_a[2];
    int m_tgt_b, m_out_b;
    bit p1, p2, p3;
    int n_edges;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    servo_slew_latch #(.NUM_SERVOS(2), .WIDTH(8), .DEFAULT_POS(127), .MAX_STEP(4), .TICK_DIV(3)) dut_a (
        .clk(clk), .rst(rst), .trigger(trigger), .pos_buffer(pos), .slew_en(slew_en),
        .target_buffer(tgt_a), .output_buffer(out_a), .settled(set_a)
    );

    servo_slew_latch #(.NUM_SERVOS(1), .WIDTH(8), .DEFAULT_POS(127), .MAX_STEP(4), .TICK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .trigger(trigger), .pos_buffer(pos[7:0]), .slew_en(slew_en),
        .target_buffer(tgt_b), .output_buffer(out_b), .settled(set_b)
    );

    assign dut_vec = {tgt_a, out_a, set_a, tgt_b, out_b, set_b};

    function automatic int move_toward(int o, int t);
        if (o < t) return o + (((t - o) > 4) ? 4 : (t - o));
        if (o > t) return o - (((o - t) > 4) ? 4 : (o - t));
        return o;
    endfunction

    // One rising edge of the spec behaviour, using the inputs currently driven.
    task automatic model_edge();
        bit lat, tick_a;
        if (rst) begin
            m_tgt_a = '{127, 127};
            m_out_a = '{127, 127};
            m_tgt_b = 127;
            m_out_b = 127;
            p1 = 0; p2 = 0; p3 = 0;
            n_edges = 0;
        end else begin
            lat = p2 && !p3;
            p3 = p2; p2 = p1; p1 = trigger;
            tick_a = (n_edges % 3) == 2;
            n_edges++;
            for (int c = 0; c < 2; c++) begin
                if (!slew_en) m_out_a[c] = lat ? int'(pos[c*8 +: 8]) : m_tgt_a[c];
                else if (tick_a) m_out_a[c] = move_toward(m_out_a[c], m_tgt_a[c]);
            end
            if (!slew_en) m_out_b = lat ? int'(pos[7:0]) : m_tgt_b;
            else m_out_b = move_toward(m_out_b, m_tgt_b);
            if (lat) begin
                m_tgt_a[0] = int'(pos[7:0]);
                m_tgt_a[1] = int'(pos[15:8]);
                m_tgt_b    = int'(pos[7:0]);
            end
        end
    endtask

    function automatic logic [49:0] model_vec();
        logic sa, sb;
        sa = (m_out_a[0] == m_tgt_a[0]) && (m_out_a[1] == m_tgt_a[1]);
        sb = (m_out_b == m_tgt_b);
        return {8'(m_tgt_a[1]), 8'(m_tgt_a[0]), 8'(m_out_a[1]), 8'(m_out_a[0]), sa,
                8'(m_tgt_b), 8'(m_out_b), sb};
    endfunction

    // Advance one clock: model follows the edge, outputs are then sampled at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; trigger = 1'b0; slew_en = 1'b0; pos = 16'($urandom);
        cyc();
        cyc();
        checks++;
        if (dut_vec !== model_vec()) begin
            fails++; $display("FAIL reset_model got=%h exp=%h", dut_vec, model_vec());
        end
        checks++;
        if ({tgt_a, out_a, set_a} !== {16'h7f7f, 16'h7f7f, 1'b1}) begin
            fails++; $display("FAIL reset_const got=%h/%h/%b exp=7f7f/7f7f/1", tgt_a, out_a, set_a);
        end
        rst = 1'b0;
    endtask

    task automatic test_direct();
        slew_en = 1'b0; pos = {8'd10, 8'd250}; trigger = 1'b0;
        cyc();
        trigger = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL direct_edge i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if ({tgt_a, out_a} !== {16'h0afa, 16'h0afa}) begin
            fails++; $display("FAIL direct_k2 got=%h/%h exp=0afa/0afa", tgt_a, out_a);
        end
        for (int i = 0; i < 50; i++) begin
            pos = 16'($urandom);
            cyc();
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL direct_hold i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (out_a !== 16'h0afa) begin
            fails++; $display("FAIL direct_no_relatch got=%h exp=0afa", out_a);
        end
        trigger = 1'b0;
        cyc();
    endtask

    task automatic test_ramp();
        logic [7:0] prev;
        rst = 1'b1; cyc(); rst = 1'b0;
        slew_en = 1'b1; pos = {8'd127, 8'd138};
        exp_q = {8'd131, 8'd135, 8'd138};
        prev = out_a[7:0];
        for (int i = 0; i < 40; i++) begin
            trigger = (i >= 1 && i < 3);
            cyc();
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL ramp_up i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            if (out_a[7:0] !== prev) begin
                checks++;
                if (exp_q.size() == 0 || out_a[7:0] !== exp_q[0]) begin
                    fails++; $display("FAIL ramp_seq got=%0d exp=%0d", out_a[7:0],
                                      (exp_q.size() == 0) ? -1 : int'(exp_q[0]));
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                prev = out_a[7:0];
            end
        end
        checks++;
        if (exp_q.size() != 0 || set_a !== 1'b1) begin
            fails++; $display("FAIL ramp_done left=%0d settled=%b exp=0/1", exp_q.size(), set_a);
        end
        pos = {8'd127, 8'd0};
        for (int i = 0; i < 160; i++) begin
            trigger = (i >= 1 && i < 3);
            cyc();
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL ramp_down i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (out_a[7:0] !== 8'd0 || set_a !== 1'b1) begin
            fails++; $display("FAIL ramp_floor got=%0d/%b exp=0/1", out_a[7:0], set_a);
        end
    endtask

    task automatic test_redirect();
        int armed;
        int peak;
        rst = 1'b1; cyc(); rst = 1'b0;
        slew_en = 1'b1; pos = {8'd127, 8'd200};
        armed = -1; peak = 0;
        for (int i = 0; i < 120; i++) begin
            if (armed < 0 && m_tgt_a[0] == 200 && m_out_a[0] == 139) begin
                armed = i;
                pos[7:0] = 8'd100;
            end
            trigger = (i >= 1 && i < 3) || (armed >= 0 && i < armed + 2);
            cyc();
            if (int'(out_a[7:0]) > peak) peak = int'(out_a[7:0]);
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL redirect i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (peak != 143 || out_a[7:0] !== 8'd100) begin
            fails++; $display("FAIL redirect_end peak=%0d final=%0d exp=143/100", peak, out_a[7:0]);
        end
        trigger = 1'b0;
    endtask

    task automatic test_mode_switch();
        rst = 1'b1; cyc(); rst = 1'b0;
        slew_en = 1'b1; pos = {8'd30, 8'd250};
        for (int i = 0; i < 12; i++) begin
            trigger = (i >= 1 && i < 3);
            cyc();
        end
        slew_en = 1'b0;
        cyc();
        checks++;
        if (out_a !== tgt_a || out_a !== 16'h1efa) begin
            fails++; $display("FAIL mode_snap got=%h exp=1efa", out_a);
        end
        slew_en = 1'b1; pos = 16'($urandom);
        for (int i = 0; i < 200; i++) begin
            trigger = (i >= 1 && i < 3);
            cyc();
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL mode_resume i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        rst = 1'b1; cyc(); rst = 1'b0;
        slew_en = 1'b1; pos = {8'd127, 8'd250};
        for (int i = 0; i < 12; i++) begin
            trigger = (i >= 1 && i < 3);
            cyc();
        end
        pos = {8'd5, 8'd5};
        trigger = 1'b1;
        cyc();
        trigger = 1'b0; rst = 1'b1;
        cyc();
        checks++;
        if ({tgt_a, out_a, set_a} !== {16'h7f7f, 16'h7f7f, 1'b1}) begin
            fails++; $display("FAIL midramp_reset got=%h/%h/%b exp=7f7f/7f7f/1", tgt_a, out_a, set_a);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL midramp_after i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (tgt_a !== 16'h7f7f) begin
            fails++; $display("FAIL midramp_no_latch got=%h exp=7f7f", tgt_a);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) trigger = ~trigger;
            if ($urandom_range(0, 31) == 0) slew_en = ~slew_en;
            if ($urandom_range(0, 3) == 0) pos = 16'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            cyc();
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_direct();
        test_ramp();
        test_redirect();
        test_mode_switch();
        test_reset_mid_ramp();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
